pipe_inv_div: RTL and testbench

//  Inverse of the 3-stage datapath F = (A+B + C-D) * D: takes result F and operand D and

---
 rtl/pipe_inv_div_if.sv | 27 ++
 rtl/pipe_inv_div.sv | 117 +++++++++++
 tb/tb_pipe_inv_div.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_inv_div_if.sv
// Handshake bundle for pipe_inv_div.
//  Input side : in_valid/in_ready carry dividend F_in and divisor D_in.
//  Output side: out_valid/out_ready carry quotient Q, remainder R, divide-by-zero dz.
//  master = producer/consumer environment, slave = the divider.
interface pipe_inv_div_if #(
  parameter int unsigned N = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] F_in;
  logic [N-1:0] D_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         dz;

  modport master (
    output in_valid, F_in, D_in, out_ready,
    input  in_ready, out_valid, Q, R, dz
  );

  modport slave (
    input  in_valid, F_in, D_in, out_ready,
    output in_ready, out_valid, Q, R, dz
  );
endinterface

// File: rtl/pipe_inv_div.sv
// Iterative restoring divider recovering X3 = F / D (and F % D) from the multiplier
// pipeline result. One division in flight; one quotient bit per clock, MSB first.
// Ports:
//  clk  - rising-edge clock
//  rst  - asynchronous reset, active-high; aborts any division in progress
//  bus  - pipe_inv_div_if.slave: in_valid/in_ready/F_in/D_in in,
//         out_valid/out_ready/Q/R/dz out (all outputs registered)
module pipe_inv_div #(
  parameter int unsigned N = 10
) (
  input logic             clk,
  input logic             rst,
  pipe_inv_div_if.slave   bus
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  q_sr;
  logic [N-1:0]  dvs;
  logic [N-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic          dz_r;

  // One restoring step. The stored remainder is always below the divisor, so it
  // fits in N bits; only the shifted trial value needs the extra top bit.
  logic [N:0]    rem_sh;
  logic          ge;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  q_next;

  assign rem_sh   = {rem, q_sr[N-1]};
  assign ge       = (rem_sh >= {1'b0, dvs});
  assign rem_next = ge ? (rem_sh[N-1:0] - dvs) : rem_sh[N-1:0];
  assign q_next   = {q_sr[N-2:0], ge};

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
      dz_r        <= 1'b0;
      cnt         <= '0;
      q_sr        <= '0;
      dvs         <= '0;
      rem         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (bus.D_in != '0) begin
              q_sr  <= bus.F_in;
              dvs   <= bus.D_in;
              rem   <= '0;
              cnt   <= CW'(N - 1);
              state <= BUSY;
            end else begin
              // Divide by zero: all-ones quotient, dividend passed through as remainder.
              q_r         <= '1;
              r_r         <= bus.F_in;
              dz_r        <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end
        BUSY: begin
          rem  <= rem_next;
          q_sr <= q_next;
          if (cnt == '0) begin
            q_r         <= q_next;
            r_r         <= rem_next;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // Result held until the consumer takes it; in_ready returns a cycle later.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Q         = q_r;
  assign bus.R         = r_r;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_pipe_inv_div.sv
// Scoreboard bench for pipe_inv_div: driver pushes expected results computed with
// plain integer division; a negedge monitor compares whatever the DUT presents.
module tb_pipe_inv_div;

  localparam int unsigned N    = 10;
  localparam int unsigned MAXV = (1 << N) - 1;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dz;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic clk;
  logic rst;
  logic stall;
  logic rnd_rdy;

  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;
  int unsigned n_sent;
  int unsigned n_out;
  logic        prev_ov;

  exp_t sb[$];

  pipe_inv_div_if #(.N(N)) bus ();

  pipe_inv_div #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks = checks + 1;
    if (act != expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks   = checks + 1;
    failures = failures + 1;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: unsigned division; divisor zero gives all ones, dividend, flag.
  function automatic exp_t model(input int unsigned f, input int unsigned d);
    exp_t m;
    if (d == 0) begin
      m.q = MAXV; m.r = f; m.dz = 1; m.lat = 0;
    end else begin
      m.q = f / d; m.r = f % d; m.dz = 0; m.lat = N;
    end
    m.acc = 0;
    return m;
  endfunction

  // Consumer readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (stall) bus.out_ready = 1'b0;
    else if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = 1'b1;
  end

  // Monitor: checks every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          if (!prev_ov) chk("latency", cyc - sb[0].acc, sb[0].lat);
          chk("Q", 32'(bus.Q), sb[0].q);
          chk("R", 32'(bus.R), sb[0].r);
          chk("dz", 32'(bus.dz), sb[0].dz);
          chk("in_ready_in_done", 32'(bus.in_ready), 0);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_out = n_out + 1;
          end
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input int unsigned f, input int unsigned d);
    int unsigned w;
    exp_t e;
    @(posedge clk); #1;
    bus.F_in     = N'(f);
    bus.D_in     = N'(d);
    bus.in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w = w + 1;
      if (w > 500) begin
        fail_now("accept_timeout");
        bus.in_valid = 1'b0;
        return;
      end
    end
    e     = model(f, d);
    e.acc = cyc + 1;
    sb.push_back(e);
    n_sent = n_sent + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Inputs change after the accept edge; the divider must ignore this.
    bus.F_in = N'($urandom);
    bus.D_in = N'($urandom);
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while (sb.size() != 0 && w < 5000) begin
      @(posedge clk);
      w = w + 1;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    int unsigned f;
    int unsigned d;
    int unsigned w;
    checks = 0; failures = 0; n_sent = 0; n_out = 0; cyc = 0;
    prev_ov = 1'b0;
    stall = 1'b0; rnd_rdy = 1'b0;
    bus.in_valid = 1'b0; bus.F_in = '0; bus.D_in = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_Q", 32'(bus.Q), 0);
    chk("rst_R", 32'(bus.R), 0);
    chk("rst_dz", 32'(bus.dz), 0);
    rst = 1'b0;

    send(600, 2);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    stall = 1'b1;
    send(600, 7);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w = w + 1;
    end
    if (!bus.out_valid) fail_now("stall_wait");
    repeat (5) @(negedge clk);
    stall = 1'b0;
    drain();

    send(123, 0);
    drain();
    send(5, 9);
    send(1023, 1);
    send(0, 3);
    drain();

    // Reset mid-division discards the operation.
    send(600, 7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    chk("abort_Q", 32'(bus.Q), 0);
    n_sent = n_sent - sb.size();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(100, 10);
    drain();

    // Random operands with a random consumer.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      f = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV);
      case ($urandom_range(0, 7))
        0:       d = 0;
        1, 2:    d = $urandom_range(1, 15);
        default: d = $urandom_range(1, MAXV);
      endcase
      send(f, d);
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    chk("result_count", n_out, n_sent);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
